// File: rtl/sha1_w_sched_pkg.sv
// Shared constants and types for the SHA-1 message schedule and the round stage
// that consumes it.
package sha1_w_sched_pkg;

    localparam int SHA1_ROUNDS  = 80;
    localparam int SHA1_WORD_W  = 32;
    localparam int SHA1_BLOCK_W = 512;
    localparam int WIN_DEPTH    = 16;
    localparam int ROUND_W      = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Round constants for the compression stage, one per 20-round quarter.
    localparam logic [SHA1_WORD_W-1:0] K_00_19 = 32'h5A82_7999;
    localparam logic [SHA1_WORD_W-1:0] K_20_39 = 32'h6ED9_EBA1;
    localparam logic [SHA1_WORD_W-1:0] K_40_59 = 32'h8F1B_BCDC;
    localparam logic [SHA1_WORD_W-1:0] K_60_79 = 32'hCA62_C1D6;

endpackage

// File: rtl/sha1_w_expand.sv
// Combinational SHA-1 schedule expansion: ROTL1(w13 ^ w8 ^ w2 ^ w0), with taps
// taken relative to the oldest word in the sliding window.
module sha1_w_expand #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] w0_i,
    input  logic [WORD_W-1:0] w2_i,
    input  logic [WORD_W-1:0] w8_i,
    input  logic [WORD_W-1:0] w13_i,
    output logic [WORD_W-1:0] w_new_o
);

    logic [WORD_W-1:0] mix;

    assign mix     = w13_i ^ w8_i ^ w2_i ^ w0_i;
    assign w_new_o = {mix[WORD_W-2:0], mix[WORD_W-1]};

endmodule

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: loads one 512-bit block and streams W[0..NUM_ROUNDS-1]
// over a valid/ready handshake using a 16-word sliding window.
module sha1_w_sched
    import sha1_w_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA1_ROUNDS,
    parameter int WORD_W     = SHA1_WORD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [16*WORD_W-1:0]      block_in,
    output logic                      busy,
    output logic [WORD_W-1:0]         w_out,
    output logic [ROUND_W-1:0]        round_out,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic                      done
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    state_e               state_q, state_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 done_q,  done_d;
    logic [WORD_W-1:0]    win_q [WIN_DEPTH];
    logic [WORD_W-1:0]    win_d [WIN_DEPTH];
    logic [WORD_W-1:0]    w_new;

    sha1_w_expand #(
        .WORD_W (WORD_W)
    ) u_expand (
        .w0_i    (win_q[0]),
        .w2_i    (win_q[2]),
        .w8_i    (win_q[8]),
        .w13_i   (win_q[13]),
        .w_new_o (w_new)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        win_d   = win_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int k = 0; k < WIN_DEPTH; k++) begin
                        win_d[k] = block_in[(WIN_DEPTH-1-k)*WORD_W +: WORD_W];
                    end
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Without a handshake nothing moves, so the outputs stay stable.
                if (w_ready) begin
                    for (int k = 0; k < WIN_DEPTH-1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[WIN_DEPTH-1] = w_new;
                    round_d            = round_q + 7'd1;
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            done_q  <= 1'b0;
            // NOTE: the window is only 16 words of flops, so it is cleared on reset to give w_out a defined value.
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    // All outputs come straight from flops: no combinational path from w_ready.
    assign busy      = (state_q == ST_RUN);
    assign w_valid   = (state_q == ST_RUN);
    assign w_out     = win_q[0];
    assign round_out = round_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha1_w_sched.sv
// Directed and random bench for sha1_w_sched against an 80-word reference schedule.
module tb_sha1_w_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic [31:0]  w_out;
    logic [6:0]   round_out;
    logic         w_valid;
    logic         w_ready;
    logic         done;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [31:0]  exp_w [80];
    logic [31:0]  got_w [80];

    sha1_w_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .block_in  (block_in),
        .busy      (busy),
        .w_out     (w_out),
        .round_out (round_out),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: full 80-word schedule using the textbook W[t-3,t-8,t-14,t-16] taps.
    task automatic compute_model(input logic [511:0] blk);
        logic [31:0] x;
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x = exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16];
            exp_w[t] = {x[30:0], x[31]};
        end
    endtask

    function automatic logic [511:0] abc_block();
        logic [511:0] b;
        b = '0;
        b[511:480] = 32'h6162_6380;
        b[31:0]    = 32'h0000_0018;
        return b;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[511-32*k -: 32] = $urandom();
        return b;
    endfunction

    // Issue start in the current (post-edge) window and check the first word.
    task automatic start_block(input logic [511:0] blk);
        compute_model(blk);
        block_in = blk;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || w_valid !== 1'b1 || round_out !== 7'd0 || w_out !== exp_w[0]) begin
            n_bad++;
            $display("FAIL first_word: got busy=%b valid=%b round=%0d w=%h want busy=1 valid=1 round=0 w=%h",
                     busy, w_valid, round_out, w_out, exp_w[0]);
        end
    endtask

    // mode 0: ready high, 1: stalls at rounds 5 and 79, 2: random ready,
    // 3: ready high with stray start pulses at rounds 10 and 79.
    task automatic stream(input int mode, input int stop_at);
        int          idx = 0;
        int          cyc = 0;
        int          stall5 = 0;
        bit          stall79 = 1'b0;
        bit          prev_stall = 1'b0;
        logic [6:0]  prev_r = '0;
        logic [31:0] prev_w = '0;
        while (idx < stop_at && cyc < 4000) begin
            case (mode)
                1: begin
                    if (idx == 5 && stall5 < 3) begin
                        w_ready = 1'b0; stall5++;
                    end else if (idx == 79 && !stall79) begin
                        w_ready = 1'b0; stall79 = 1'b1;
                    end else begin
                        w_ready = 1'b1;
                    end
                end
                2: w_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    w_ready = 1'b1;
                    if (idx == 10 || idx == 79) begin
                        start    = 1'b1;
                        block_in = '0;
                    end
                end
                default: w_ready = 1'b1;
            endcase
            n_cmp++;
            if (w_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL run_ctrl r%0d: got valid=%b busy=%b done=%b want 1 1 0", idx, w_valid, busy, done);
            end
            n_cmp++;
            if (round_out !== 7'(idx) || w_out !== exp_w[idx]) begin
                n_bad++;
                $display("FAIL word r%0d: got round=%0d w=%h want round=%0d w=%h",
                         idx, round_out, w_out, idx, exp_w[idx]);
            end
            if (prev_stall) begin
                n_cmp++;
                if (round_out !== prev_r || w_out !== prev_w) begin
                    n_bad++;
                    $display("FAIL frozen r%0d: got round=%0d w=%h want round=%0d w=%h",
                             idx, round_out, w_out, prev_r, prev_w);
                end
            end
            prev_stall = !w_ready;
            prev_r     = round_out;
            prev_w     = w_out;
            if (w_ready) begin
                got_w[idx] = w_out;
                idx++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        w_ready = 1'b1;
        start   = 1'b0;
        if (idx < stop_at) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d handshakes want %0d", idx, stop_at);
        end else if (stop_at == 80) begin
            n_cmp++;
            if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL block_end: got done=%b busy=%b valid=%b want 1 0 0", done, busy, w_valid);
            end
        end
    endtask

    // One cycle after the done cycle: the pulse must be gone and nothing restarted.
    task automatic check_done_cleared(input string name);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after_done: got done=%b valid=%b busy=%b want 0 0 0", name, done, w_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; w_ready = 1'b1; block_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got busy=%b valid=%b done=%b want 0 0 0", busy, w_valid, done);
        end
        n_cmp++;
        if (round_out !== 7'd0 || w_out !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got round=%0d w=%h want 0 00000000", round_out, w_out);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: got busy=%b valid=%b want 0 0", busy, w_valid);
        end
    endtask

    task automatic test_abc();
        logic [31:0] want [6];
        int          at   [6];
        want = '{32'h6162_6380, 32'h0000_0018, 32'hC2C4_C700, 32'h0000_0000, 32'h0000_0030, 32'h8589_8E01};
        at   = '{0, 15, 16, 17, 18, 19};
        start_block(abc_block());
        stream(0, 80);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got_w[at[i]] !== want[i]) begin
                n_bad++;
                $display("FAIL abc_w%0d: got %h want %h", at[i], got_w[at[i]], want[i]);
            end
        end
        check_done_cleared("abc");
    endtask

    task automatic test_backpressure();
        start_block(abc_block());
        stream(1, 80);
        n_cmp++;
        if (got_w[19] !== 32'h8589_8E01) begin
            n_bad++;
            $display("FAIL bp_w19: got %h want 85898e01", got_w[19]);
        end
        check_done_cleared("bp");
    endtask

    task automatic test_start_ignored();
        start_block(abc_block());
        stream(3, 80);
        check_done_cleared("start_ign");
    endtask

    task automatic test_back_to_back();
        start_block(abc_block());
        stream(0, 80);
        start_block({512{1'b1}});
        stream(0, 80);
        n_cmp++;
        if (got_w[0] !== 32'hFFFF_FFFF || got_w[16] !== 32'h0000_0000) begin
            n_bad++;
            $display("FAIL b2b_words: got w0=%h w16=%h want ffffffff 00000000", got_w[0], got_w[16]);
        end
        check_done_cleared("b2b");
    endtask

    task automatic test_reset_mid();
        start_block(abc_block());
        stream(0, 40);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || w_valid !== 1'b0 || done !== 1'b0 || round_out !== 7'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got busy=%b valid=%b done=%b round=%0d want 0 0 0 0",
                     busy, w_valid, done, round_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || w_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_nodone: got done=%b valid=%b want 0 0", done, w_valid);
        end
        start_block(rand_block());
        stream(0, 80);
        check_done_cleared("restart");
    endtask

    task automatic test_random();
        for (int b = 0; b < 100; b++) begin
            start_block(rand_block());
            stream(2, 80);
            check_done_cleared("rand");
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
